issue_reservation_station: RTL and testbench

- Single reservation station between rename/dispatch and the functional units.
- Holds renamed instructions until both source operands are available, captures operand values from the common data bus (CDB), and issues at most one instruction per cycle to a free FU.
- Issue-side ports are the producer side of the FU_IF RS modport, one lane per FU.

---
 rtl/rs_pkg.sv | 60 ++++++
 rtl/issue_reservation_station_prio_enc.sv | 29 ++
 rtl/issue_reservation_station.sv | 154 +++++++++++++++
 tb/tb_issue_reservation_station.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// ============================================================================
// Module      : rs_pkg
// Description : Shared types and helpers for the issue reservation station.
// Revision    : 1.0
// ============================================================================
`default_nettype none

`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

package rs_pkg;

    localparam int RS_DEPTH_DEF  = 8;
    localparam int NUM_OF_FU_DEF = 4;
    localparam int RS_IDX_W      = $clog2(RS_DEPTH_DEF);

    typedef struct packed {
        logic [3:0] alu_op;
        logic       use_imm;
        logic [2:0] fu_type;
    } control_t;

    typedef struct packed {
        logic [`PHYSICAL_REG_NUM_WIDTH-1:0] tag;
        logic                               rdy;
        logic [`REG_VAL_WIDTH-1:0]          val;
    } rs_src_t;

    typedef struct packed {
        logic                               valid;
        rs_src_t                            src1;
        rs_src_t                            src2;
        logic [`PHYSICAL_REG_NUM_WIDTH-1:0] dst;
        control_t                           control;
        logic [`REG_VAL_WIDTH-1:0]          imm;
    } rs_entry_t;

    // Capture a CDB broadcast into a waiting source; ready sources are left untouched.
    function automatic rs_src_t src_wakeup(
        input rs_src_t                            src,
        input logic                               cdb_valid,
        input logic [`PHYSICAL_REG_NUM_WIDTH-1:0] cdb_tag,
        input logic [`REG_VAL_WIDTH-1:0]          cdb_val
    );
        rs_src_t res;
        res = src;
        if (!src.rdy && cdb_valid && (src.tag == cdb_tag)) begin
            res.rdy = 1'b1;
            res.val = cdb_val;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/issue_reservation_station_prio_enc.sv
// ============================================================================
// Module      : rs_prio_enc
// Description : Lowest-index-set priority encoder returning {found, index}.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rs_prio_enc #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    always_comb begin
        found = |req;
        index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/issue_reservation_station.sv
// ============================================================================
// Module      : issue_reservation_station
// Description : Reservation station with CDB wakeup and single-issue select.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module issue_reservation_station
    import rs_pkg::*;
#(
    parameter int RS_DEPTH  = RS_DEPTH_DEF,
    parameter int NUM_OF_FU = NUM_OF_FU_DEF
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               disp_valid,
    output logic                               disp_ready,
    input  logic [`PHYSICAL_REG_NUM_WIDTH-1:0] disp_src1_tag,
    input  logic                               disp_src1_rdy,
    input  logic [`REG_VAL_WIDTH-1:0]          disp_src1_val,
    input  logic [`PHYSICAL_REG_NUM_WIDTH-1:0] disp_src2_tag,
    input  logic                               disp_src2_rdy,
    input  logic [`REG_VAL_WIDTH-1:0]          disp_src2_val,
    input  logic [`PHYSICAL_REG_NUM_WIDTH-1:0] disp_dst_tag,
    input  control_t                           disp_control,
    input  logic [`REG_VAL_WIDTH-1:0]          disp_imm,
    input  logic                               cdb_valid,
    input  logic [`PHYSICAL_REG_NUM_WIDTH-1:0] cdb_tag,
    input  logic [`REG_VAL_WIDTH-1:0]          cdb_val,
    input  logic [NUM_OF_FU-1:0]               fu_ready,
    output logic [NUM_OF_FU-1:0]               fu_valid,
    output logic [`REG_VAL_WIDTH-1:0]          fu_src1_reg_val [NUM_OF_FU],
    output logic [`REG_VAL_WIDTH-1:0]          fu_src2_reg_val [NUM_OF_FU],
    output logic [`PHYSICAL_REG_NUM_WIDTH-1:0] fu_dst_reg_addr [NUM_OF_FU],
    output control_t                           fu_control      [NUM_OF_FU],
    output logic [`REG_VAL_WIDTH-1:0]          fu_immediate    [NUM_OF_FU],
    output logic [$clog2(RS_DEPTH):0]          rs_count
);

    localparam int IDX_W    = $clog2(RS_DEPTH);
    localparam int FU_IDX_W = (NUM_OF_FU > 1) ? $clog2(NUM_OF_FU) : 1;
    localparam int CNT_W    = IDX_W + 1;

    rs_entry_t             r_entries [RS_DEPTH];
    logic [CNT_W-1:0]      r_count;

    logic [RS_DEPTH-1:0]   w_valid;
    logic [RS_DEPTH-1:0]   w_free;
    logic [RS_DEPTH-1:0]   w_eligible;
    logic                  w_alloc_found;
    logic                  w_sel_found;
    logic                  w_fu_found;
    logic [IDX_W-1:0]      w_alloc_idx;
    logic [IDX_W-1:0]      w_sel_idx;
    logic [FU_IDX_W-1:0]   w_fu_idx;
    logic                  w_dispatch;
    logic                  w_issue;
    rs_src_t               w_disp_src1;
    rs_src_t               w_disp_src2;
    rs_entry_t             w_new_entry;

    for (genvar i = 0; i < RS_DEPTH; i++) begin : g_flags
        assign w_valid[i]    = r_entries[i].valid;
        assign w_free[i]     = ~r_entries[i].valid;
        assign w_eligible[i] = r_entries[i].valid & r_entries[i].src1.rdy & r_entries[i].src2.rdy;
    end

    rs_prio_enc #(
        .WIDTH (RS_DEPTH),
        .IDX_W (IDX_W)
    ) u_alloc_enc (
        .req   (w_free),
        .found (w_alloc_found),
        .index (w_alloc_idx)
    );

    rs_prio_enc #(
        .WIDTH (RS_DEPTH),
        .IDX_W (IDX_W)
    ) u_sel_enc (
        .req   (w_eligible),
        .found (w_sel_found),
        .index (w_sel_idx)
    );

    rs_prio_enc #(
        .WIDTH (NUM_OF_FU),
        .IDX_W (FU_IDX_W)
    ) u_fu_enc (
        .req   (fu_ready),
        .found (w_fu_found),
        .index (w_fu_idx)
    );

    assign disp_ready = ~&w_valid;
    assign w_dispatch = disp_valid & w_alloc_found;
    // The selected lane is ready by construction, so select implies transfer.
    assign w_issue    = w_sel_found & w_fu_found;
    assign rs_count   = r_count;

    always_comb begin
        w_disp_src1.tag = disp_src1_tag;
        w_disp_src1.rdy = disp_src1_rdy;
        w_disp_src1.val = disp_src1_val;
        w_disp_src2.tag = disp_src2_tag;
        w_disp_src2.rdy = disp_src2_rdy;
        w_disp_src2.val = disp_src2_val;

        w_new_entry.valid   = 1'b1;
        w_new_entry.src1    = src_wakeup(w_disp_src1, cdb_valid, cdb_tag, cdb_val);
        w_new_entry.src2    = src_wakeup(w_disp_src2, cdb_valid, cdb_tag, cdb_val);
        w_new_entry.dst     = disp_dst_tag;
        w_new_entry.control = disp_control;
        w_new_entry.imm     = disp_imm;
    end

    // Dispatch only targets a free entry and issue only a valid one, so they never collide.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (reset || flush) begin
                r_entries[i].valid <= 1'b0;
            end else if (w_dispatch && (w_alloc_idx == IDX_W'(i))) begin
                r_entries[i] <= w_new_entry;
            end else begin
                r_entries[i].src1 <= src_wakeup(r_entries[i].src1, cdb_valid, cdb_tag, cdb_val);
                r_entries[i].src2 <= src_wakeup(r_entries[i].src2, cdb_valid, cdb_tag, cdb_val);
                if (w_issue && (w_sel_idx == IDX_W'(i))) begin
                    r_entries[i].valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(w_dispatch) - CNT_W'(w_issue);
        end
    end

    for (genvar k = 0; k < NUM_OF_FU; k++) begin : g_lane
        assign fu_valid[k]        = w_issue && (w_fu_idx == FU_IDX_W'(k));
        assign fu_src1_reg_val[k] = r_entries[w_sel_idx].src1.val;
        assign fu_src2_reg_val[k] = r_entries[w_sel_idx].src2.val;
        assign fu_dst_reg_addr[k] = r_entries[w_sel_idx].dst;
        assign fu_control[k]      = r_entries[w_sel_idx].control;
        assign fu_immediate[k]    = r_entries[w_sel_idx].imm;
    end

endmodule

`default_nettype wire

// File: tb/tb_issue_reservation_station.sv
// ============================================================================
// Module      : tb_issue_reservation_station
// Description : Scoreboard bench for the issue reservation station.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_issue_reservation_station;
    import rs_pkg::*;

    localparam int NFU = 4;
    localparam int PW  = `PHYSICAL_REG_NUM_WIDTH;
    localparam int VW  = `REG_VAL_WIDTH;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              disp_valid;
    logic              disp_ready;
    logic [PW-1:0]     disp_src1_tag;
    logic              disp_src1_rdy;
    logic [VW-1:0]     disp_src1_val;
    logic [PW-1:0]     disp_src2_tag;
    logic              disp_src2_rdy;
    logic [VW-1:0]     disp_src2_val;
    logic [PW-1:0]     disp_dst_tag;
    control_t          disp_control;
    logic [VW-1:0]     disp_imm;
    logic              cdb_valid;
    logic [PW-1:0]     cdb_tag;
    logic [VW-1:0]     cdb_val;
    logic [NFU-1:0]    fu_ready;
    logic [NFU-1:0]    fu_valid;
    logic [VW-1:0]     fu_src1_reg_val [NFU];
    logic [VW-1:0]     fu_src2_reg_val [NFU];
    logic [PW-1:0]     fu_dst_reg_addr [NFU];
    control_t          fu_control      [NFU];
    logic [VW-1:0]     fu_immediate    [NFU];
    logic [3:0]        rs_count;

    typedef struct {
        int            lane;
        logic [VW-1:0] s1;
        logic [VW-1:0] s2;
        logic [PW-1:0] dst;
        logic [VW-1:0] imm;
        logic [7:0]    ctl;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    issue_reservation_station #(.RS_DEPTH(8), .NUM_OF_FU(NFU)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .disp_valid      (disp_valid),
        .disp_ready      (disp_ready),
        .disp_src1_tag   (disp_src1_tag),
        .disp_src1_rdy   (disp_src1_rdy),
        .disp_src1_val   (disp_src1_val),
        .disp_src2_tag   (disp_src2_tag),
        .disp_src2_rdy   (disp_src2_rdy),
        .disp_src2_val   (disp_src2_val),
        .disp_dst_tag    (disp_dst_tag),
        .disp_control    (disp_control),
        .disp_imm        (disp_imm),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_val         (cdb_val),
        .fu_ready        (fu_ready),
        .fu_valid        (fu_valid),
        .fu_src1_reg_val (fu_src1_reg_val),
        .fu_src2_reg_val (fu_src2_reg_val),
        .fu_dst_reg_addr (fu_dst_reg_addr),
        .fu_control      (fu_control),
        .fu_immediate    (fu_immediate),
        .rs_count        (rs_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ctl_of(input int dst);
        return 8'(dst) ^ 8'h5A;
    endfunction

    task automatic push_exp(input int lane, input int s1, input int s2, input int dst, input int imm);
        exp_t e;
        e.lane = lane;
        e.s1   = VW'(s1);
        e.s2   = VW'(s2);
        e.dst  = PW'(dst);
        e.imm  = VW'(imm);
        e.ctl  = ctl_of(dst);
        exp_q.push_back(e);
    endtask

    task automatic set_disp(input int t1, input int r1, input int v1, input int t2, input int r2,
                            input int v2, input int dst, input int imm);
        disp_src1_tag = PW'(t1);
        disp_src1_rdy = (r1 != 0);
        disp_src1_val = VW'(v1);
        disp_src2_tag = PW'(t2);
        disp_src2_rdy = (r2 != 0);
        disp_src2_val = VW'(v2);
        disp_dst_tag  = PW'(dst);
        disp_control  = control_t'(ctl_of(dst));
        disp_imm      = VW'(imm);
        disp_valid    = 1'b1;
    endtask

    task automatic disp(input int t1, input int r1, input int v1, input int t2, input int r2,
                        input int v2, input int dst, input int imm);
        set_disp(t1, r1, v1, t2, r2, v2, dst, imm);
        step();
        disp_valid = 1'b0;
    endtask

    // Monitor: every transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && !flush) begin
            for (int k = 0; k < NFU; k++) begin
                if (fu_valid[k] && fu_ready[k]) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_issue: lane %0d src1 %0h got issue expected none",
                                 k, fu_src1_reg_val[k]);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("issue_lane", 64'(k), 64'(mon_e.lane));
                        check("issue_src1", 64'(fu_src1_reg_val[k]), 64'(mon_e.s1));
                        check("issue_src2", 64'(fu_src2_reg_val[k]), 64'(mon_e.s2));
                        check("issue_dst", 64'(fu_dst_reg_addr[k]), 64'(mon_e.dst));
                        check("issue_imm", 64'(fu_immediate[k]), 64'(mon_e.imm));
                        check("issue_ctl", 64'(fu_control[k]), 64'(mon_e.ctl));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; disp_valid = 1'b0;
        disp_src1_tag = '0; disp_src1_rdy = 1'b0; disp_src1_val = '0;
        disp_src2_tag = '0; disp_src2_rdy = 1'b0; disp_src2_val = '0;
        disp_dst_tag = '0; disp_control = '0; disp_imm = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0; fu_ready = '0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        check("reset_disp_ready", 64'(disp_ready), 64'd1);
        check("reset_count", 64'(rs_count), 64'd0);
        check("reset_fu_valid", 64'(fu_valid), 64'd0);

        // Basic dispatch and issue on lane 2
        step();
        fu_ready = 4'b0100;
        push_exp(2, 'h10, 'h20, 7, 'h111);
        disp(5, 1, 'h10, 6, 1, 'h20, 7, 'h111);
        @(negedge clk);
        check("t1_fu_valid", 64'(fu_valid), 64'b0100);
        check("t1_count", 64'(rs_count), 64'd1);
        step();
        @(negedge clk);
        check("t1_count_after", 64'(rs_count), 64'd0);
        check("t1_idle", 64'(fu_valid), 64'd0);

        // CDB wakeup of a waiting source
        step();
        fu_ready = 4'b0001;
        push_exp(0, 'h1, 'hABCD, 8, 'h222);
        disp(3, 1, 'h1, 9, 0, 'h0, 8, 'h222);
        @(negedge clk);
        check("t2_waiting", 64'(fu_valid), 64'd0);
        step();
        cdb_valid = 1'b1; cdb_tag = PW'(9); cdb_val = VW'('hABCD);
        @(negedge clk);
        check("t2_wake_cycle", 64'(fu_valid), 64'd0);
        step();
        cdb_valid = 1'b0;
        @(negedge clk);
        check("t2_issue_next", 64'(fu_valid), 64'b0001);
        step();
        @(negedge clk);
        check("t2_count_after", 64'(rs_count), 64'd0);

        // Dispatch bypass from the CDB
        step();
        fu_ready = 4'b1000;
        cdb_valid = 1'b1; cdb_tag = PW'(12); cdb_val = VW'('h777);
        push_exp(3, 'h777, 'h5, 10, 'h333);
        disp(12, 0, 'h0, 13, 1, 'h5, 10, 'h333);
        cdb_valid = 1'b0;
        @(negedge clk);
        check("t3_bypass_issue", 64'(fu_valid), 64'b1000);
        step();
        @(negedge clk);
        check("t3_count_after", 64'(rs_count), 64'd0);

        // Fill, drop a 9th dispatch, then drain in index order
        step();
        fu_ready = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            push_exp(0, 'h100 + i, 'h200 + i, 16 + i, 'h400 + i);
            disp(20 + i, 1, 'h100 + i, 30 + i, 1, 'h200 + i, 16 + i, 'h400 + i);
        end
        @(negedge clk);
        check("full_disp_ready", 64'(disp_ready), 64'd0);
        check("full_count", 64'(rs_count), 64'd8);
        disp(50, 1, 'h999, 51, 1, 'h999, 60, 'h999);
        @(negedge clk);
        check("drop_count", 64'(rs_count), 64'd8);
        check("drop_disp_ready", 64'(disp_ready), 64'd0);
        step();
        fu_ready = 4'b0001;
        @(negedge clk);
        check("t4_first_issue", 64'(fu_valid), 64'b0001);
        step();
        @(negedge clk);
        check("t4_ready_after", 64'(disp_ready), 64'd1);
        check("t4_count_after", 64'(rs_count), 64'd7);
        repeat (7) step();
        @(negedge clk);
        check("t4_drained", 64'(rs_count), 64'd0);

        // Entries 2 and 5 eligible; others wait on tag 40
        step();
        fu_ready = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            if (i == 2 || i == 5) begin
                push_exp(0, 'h500 + i, 'h600 + i, i, 'h700 + i);
                disp(1, 1, 'h500 + i, 2, 1, 'h600 + i, i, 'h700 + i);
            end else begin
                disp(40, 0, 'h0, 2, 1, 'h600 + i, i, 'h700 + i);
            end
        end
        @(negedge clk);
        check("t5_count", 64'(rs_count), 64'd6);
        check("t5_idle", 64'(fu_valid), 64'd0);
        step();
        fu_ready = 4'b1111;
        @(negedge clk);
        check("t5_first", 64'(fu_valid), 64'b0001);
        step();
        @(negedge clk);
        check("t5_second", 64'(fu_valid), 64'b0001);
        check("t5_count_mid", 64'(rs_count), 64'd5);
        step();
        @(negedge clk);
        check("t5_none", 64'(fu_valid), 64'd0);
        check("t5_count_end", 64'(rs_count), 64'd4);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        check("t5_flush_count", 64'(rs_count), 64'd0);
        check("t5_flush_valid", 64'(fu_valid), 64'd0);

        // Flush with three ready entries and a pending dispatch
        step();
        fu_ready = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            disp(i + 1, 1, 'h800 + i, i + 4, 1, 'h900 + i, 20 + i, 'hA00 + i);
        end
        @(negedge clk);
        check("t6_count_pre", 64'(rs_count), 64'd3);
        step();
        flush = 1'b1;
        set_disp(7, 1, 'hB00, 8, 1, 'hB01, 30, 'hB02);
        step();
        flush = 1'b0;
        disp_valid = 1'b0;
        fu_ready = 4'b1111;
        @(negedge clk);
        check("t6_count", 64'(rs_count), 64'd0);
        check("t6_fu_valid", 64'(fu_valid), 64'd0);
        check("t6_disp_ready", 64'(disp_ready), 64'd1);
        step();
        @(negedge clk);
        check("t6_still_idle", 64'(fu_valid), 64'd0);
        check("t6_count_hold", 64'(rs_count), 64'd0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
